mem_axi_rd_arbiter: RTL and testbench
=====================================

Name: mem_axi_rd_arbiter

Overview:
- Shares the single AXI read channel between the ICache refill, DCache refill and uncached-load requesters.
- Accepts one read burst at a time, registers its address phase onto the AXI AR channel, then routes R beats back to the granted requester until RLAST.
- Sits between the cache and uncache AXI masters and the top-level AXI interconnect port.

Parameters:
- N_REQ, 3, number of requesters. Index 0 is ICache, 1 is DCache, 2 is uncache.
- ADDR_W, 32, address width.
- DATA_W, 32, read data width.
- ID_W, 4, AXI ARID width. Must satisfy 2^ID_W >= N_REQ.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req_arvalid  in  N_REQ  per-requester read request valid
- req_arready  out  N_REQ  per-requester request accepted (one-cycle pulse)
- req_araddr  in  N_REQ*ADDR_W  per-requester start address; slice i is bits [i*ADDR_W +: ADDR_W]
- req_arlen  in  N_REQ*8  per-requester burst length minus 1
- req_arsize  in  N_REQ*3  per-requester beat size
- req_rvalid  out  N_REQ  per-requester read beat valid
- req_rdata  out  DATA_W  read data, shared by all requesters
- req_rlast  out  1  last beat, shared
- req_rresp  out  2  response code, shared
- req_rready  in  N_REQ  per-requester beat ready
- m_arvalid  out  1  AXI AR valid
- m_arready  in  1  AXI AR ready
- m_araddr  out  ADDR_W  AXI AR address
- m_arlen  out  8  AXI AR length
- m_arsize  out  3  AXI AR size
- m_arburst  out  2  AXI AR burst type, constant 2'b01 (INCR)
- m_arid  out  ID_W  grant index, zero-extended
- m_rvalid  in  1  AXI R valid
- m_rdata  in  DATA_W  AXI R data
- m_rlast  in  1  AXI R last
- m_rresp  in  2  AXI R response
- m_rready  out  1  AXI R ready
- busy  out  1  high when the FSM is not in IDLE
- err  out  1  sticky beat-count mismatch flag

Behaviour:
- Reset (asynchronous, rst=1) forces:
  - FSM to IDLE and grant pointer to 0;
  - m_arvalid=0, m_araddr/m_arlen/m_arsize/m_arid=0;
  - req_arready=0, req_rvalid=0, busy=0, err=0;
  - beat counter to 0.
- A reset asserted in any state aborts the transfer immediately. No R beats are routed after reset deasserts.
- FSM has three states: IDLE, ADDR, DATA.
- IDLE:
  - If any req_arvalid is high, select grant g. Same cycle: req_arready[g]=1; latch araddr/arlen/arsize slice g and g into the registers. Next state is ADDR.
  - Otherwise stay in IDLE; all req_arready=0.
- ADDR:
  - m_arvalid=1, driven from registers only (no combinational path from req_* to m_ar*).
  - m_ar* stay stable while m_arvalid=1 and m_arready=0.
  - On m_arready=1, go to DATA. m_arvalid=0 from the next cycle.
- DATA:
  - req_rvalid[g]=m_rvalid; all other req_rvalid bits are 0.
  - req_rdata/req_rlast/req_rresp pass m_* through combinationally.
  - m_rready=req_rready[g].
  - Each handshake (m_rvalid & m_rready) increments the beat counter.
  - A handshake with m_rlast=1 moves to IDLE, clears the counter, and sets pointer = (g+1) mod N_REQ.
- R beats arriving in IDLE or ADDR get m_rready=0 and are not forwarded.
- Latency: request accepted at cycle T, m_arvalid is high at T+1.
- Back-to-back: after the RLAST handshake there is at least one IDLE cycle before the next m_arvalid, so the next req_arready is at the earliest in the cycle after RLAST.
- Simultaneous requests are resolved by the grant policy (see Optional Feature). A requester whose req_arvalid stays high keeps waiting; it must hold its payload stable until req_arready.
- err (sticky until reset) is set when either:
  - RLAST is handshaked with beat count != latched arlen; or
  - a handshake occurs with beat count == arlen and m_rlast=0.
- After an error the FSM still follows RLAST.
- busy = (state != IDLE).

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin grant. Search starts at the pointer index and wraps; the first requesting index wins. The pointer updates on RLAST as described above.
- Undefined: fixed priority, DCache (1) > uncache (2) > ICache (0). The pointer register is not implemented. The grant depends only on the current req_arvalid.

Test Plan:
1. Single burst, no stall:
   - Stimulus: req1 araddr=0x1FC0_0040, arlen=3, arsize=2; m_arready=1; 4 beats D0..D3, RLAST on D3; req_rready[1]=1.
   - Required: m_arvalid high at T+1; m_arid=1; req1 receives D0..D3; req_rvalid[0], req_rvalid[2]=0; err=0; busy returns to 0.
2. AR stall:
   - Stimulus: m_arready=0 for 5 cycles.
   - Required: m_arvalid and m_araddr held constant; no R routing until DATA.
3. Simultaneous requests:
   - Stimulus: req0, req1, req2 all requesting, arlen=0 each.
   - Required with MEM_ARB_RR_EN: grant order 0,1,2 from reset.
   - Required without MEM_ARB_RR_EN: grant order 1,2,0.
4. Back-pressure:
   - Stimulus: req_rready[g]=0 for 3 cycles mid-burst while m_rvalid=1.
   - Required: m_rready=0 for those cycles; no beat lost or duplicated.
5. Length mismatch:
   - Stimulus: arlen=3, m_rlast asserted on beat 2.
   - Required: err=1 and stays 1; FSM returns to IDLE; the next request is served normally.
6. Reset mid-DATA:
   - Stimulus: rst=1 pulse after 2 of 4 beats.
   - Required: all outputs at reset values immediately; req_rvalid=0; a new request after reset is granted to index 0 (round-robin) or index 1 (fixed) when all three request.

Source files
------------

// File: rtl/mem_axi_rd_arbiter_if.sv
// Requester-side and AXI-read-side signals of the shared read-channel arbiter.
// master is the arbiter's view; slave is the requesters/interconnect view.
interface mem_axi_rd_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic [N_REQ-1:0]        req_arvalid;
  logic [N_REQ-1:0]        req_arready;
  logic [N_REQ*ADDR_W-1:0] req_araddr;
  logic [N_REQ*8-1:0]      req_arlen;
  logic [N_REQ*3-1:0]      req_arsize;
  logic [N_REQ-1:0]        req_rvalid;
  logic [DATA_W-1:0]       req_rdata;
  logic                    req_rlast;
  logic [1:0]              req_rresp;
  logic [N_REQ-1:0]        req_rready;

  logic                    m_arvalid;
  logic                    m_arready;
  logic [ADDR_W-1:0]       m_araddr;
  logic [7:0]              m_arlen;
  logic [2:0]              m_arsize;
  logic [1:0]              m_arburst;
  logic [ID_W-1:0]         m_arid;
  logic                    m_rvalid;
  logic [DATA_W-1:0]       m_rdata;
  logic                    m_rlast;
  logic [1:0]              m_rresp;
  logic                    m_rready;

  modport master (
    input  req_arvalid, req_araddr, req_arlen, req_arsize, req_rready,
           m_arready, m_rvalid, m_rdata, m_rlast, m_rresp,
    output req_arready, req_rvalid, req_rdata, req_rlast, req_rresp,
           m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_arid, m_rready
  );

  modport slave (
    output req_arvalid, req_araddr, req_arlen, req_arsize, req_rready,
           m_arready, m_rvalid, m_rdata, m_rlast, m_rresp,
    input  req_arready, req_rvalid, req_rdata, req_rlast, req_rresp,
           m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_arid, m_rready
  );
endinterface

// File: rtl/mem_axi_rd_arbiter.sv
// Shares one AXI read channel between ICache, DCache and uncache requesters.
// MEM_ARB_RR_EN selects round-robin grant; otherwise fixed priority 1 > 2 > 0.
//
// state | meaning
// IDLE  | no burst open; grant and latch address phase of a requester
// ADDR  | registered AR presented on the AXI port, waiting for m_arready
// DATA  | R beats routed to the granted requester until RLAST
module mem_axi_rd_arbiter #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_axi_rd_arbiter_if.master bus,
  output logic                 busy,
  output logic                 err
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]        state;
  logic [GW-1:0]     gnt_q;
  logic [GW-1:0]     gnt_c;
  logic              found;
  logic              any_req;
  logic              hs;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [7:0]        cnt_q;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_len;
  logic [2:0]        sel_size;
`ifdef MEM_ARB_RR_EN
  logic [GW-1:0]     ptr_q;
`endif

  assign any_req = |bus.req_arvalid;
  assign busy    = (state != S_IDLE);
  assign hs      = (state == S_DATA) && bus.m_rvalid && bus.m_rready;

  always_comb begin
    gnt_c = '0;
    found = 1'b0;
`ifdef MEM_ARB_RR_EN
    // k-th candidate after the pointer is index i when ptr+k == i (mod N_REQ)
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && bus.req_arvalid[i] &&
            ((int'(ptr_q) + k == i) || (int'(ptr_q) + k == i + N_REQ))) begin
          gnt_c = GW'(i);
          found = 1'b1;
        end
      end
    end
`else
    for (int i = 1; i < N_REQ; i++) begin
      if (!found && bus.req_arvalid[i]) begin
        gnt_c = GW'(i);
        found = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    sel_size = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_c == GW'(i)) begin
        sel_addr = bus.req_araddr[i*ADDR_W +: ADDR_W];
        sel_len  = bus.req_arlen[i*8 +: 8];
        sel_size = bus.req_arsize[i*3 +: 3];
      end
    end
  end

  always_comb begin
    bus.req_arready = '0;
    bus.req_rvalid  = '0;
    bus.m_rready    = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if ((state == S_IDLE) && any_req && !rst && (gnt_c == GW'(i)))
        bus.req_arready[i] = 1'b1;
      if ((state == S_DATA) && (gnt_q == GW'(i))) begin
        bus.req_rvalid[i] = bus.m_rvalid;
        bus.m_rready      = bus.req_rready[i];
      end
    end
  end

  assign bus.req_rdata = bus.m_rdata;
  assign bus.req_rlast = bus.m_rlast;
  assign bus.req_rresp = bus.m_rresp;

  assign bus.m_arvalid = (state == S_ADDR);
  assign bus.m_araddr  = addr_q;
  assign bus.m_arlen   = len_q;
  assign bus.m_arsize  = size_q;
  assign bus.m_arburst = 2'b01;
  assign bus.m_arid    = ID_W'(gnt_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      gnt_q  <= '0;
      addr_q <= '0;
      len_q  <= '0;
      size_q <= '0;
      cnt_q  <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            state  <= S_ADDR;
            gnt_q  <= gnt_c;
            addr_q <= sel_addr;
            len_q  <= sel_len;
            size_q <= sel_size;
          end
        end
        S_ADDR: begin
          if (bus.m_arready) state <= S_DATA;
        end
        S_DATA: begin
          if (hs) begin
            // early RLAST or missing RLAST on the expected final beat
            if ((bus.m_rlast && (cnt_q != len_q)) || (!bus.m_rlast && (cnt_q == len_q)))
              err <= 1'b1;
            if (bus.m_rlast) begin
              state <= S_IDLE;
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr_q <= '0;
    else if (hs && bus.m_rlast)
      ptr_q <= (gnt_q == GW'(N_REQ-1)) ? '0 : gnt_q + 1'b1;
  end
`endif
endmodule

// File: tb/tb_mem_axi_rd_arbiter.sv
// Directed bench for mem_axi_rd_arbiter: cycle table for a plain burst plus
// hand sequences for stall, arbitration, back-pressure, errors and reset.
module tb_mem_axi_rd_arbiter;
  localparam int N_REQ  = 3;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic err;

  mem_axi_rd_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  mem_axi_rd_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .err  (err)
  );

  always #5 clk = ~clk;

  logic [ADDR_W-1:0] p_addr [N_REQ];
  logic [7:0]        p_len  [N_REQ];
  logic [2:0]        p_size [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_araddr[i*ADDR_W +: ADDR_W] = p_addr[i];
      bus.req_arlen[i*8 +: 8]            = p_len[i];
      bus.req_arsize[i*3 +: 3]           = p_size[i];
    end
  end

  typedef struct {
    logic [2:0]  arvalid;
    logic        m_arready;
    logic        m_rvalid;
    logic        m_rlast;
    logic [31:0] m_rdata;
    logic [2:0]  rready;
    logic [2:0]  e_arready;
    logic        e_arvalid;
    logic [31:0] e_araddr;
    logic [3:0]  e_arid;
    logic [2:0]  e_rvalid;
    logic        e_rready;
    logic        e_busy;
  } vec_t;

  vec_t tv [7];
  int   checks = 0;
  int   errors = 0;
  int   order [3];
  int   rst_gnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic logic [2:0] oh(input int g);
    return 3'b001 << g;
  endfunction

  task automatic idle_inputs();
    bus.req_arvalid = '0;
    bus.req_rready  = '0;
    bus.m_arready   = 1'b0;
    bus.m_rvalid    = 1'b0;
    bus.m_rlast     = 1'b0;
    bus.m_rdata     = '0;
    bus.m_rresp     = 2'b00;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // request cycle in IDLE followed by the AR handshake cycle
  task automatic start_burst(input int g, input logic [2:0] vmask);
    tick();
    idle_inputs();
    bus.req_arvalid = vmask;
    settle();
    chk("sb_arready", bus.req_arready, oh(g));
    tick();
    bus.req_arvalid = vmask & ~oh(g);
    bus.m_arready   = 1'b1;
    settle();
    chk("sb_m_arvalid", bus.m_arvalid, 1);
    chk("sb_m_arid", bus.m_arid, g);
  endtask

  task automatic beat(input logic [31:0] d, input logic last, input logic [2:0] rr);
    tick();
    bus.m_arready  = 1'b0;
    bus.m_rvalid   = 1'b1;
    bus.m_rdata    = d;
    bus.m_rlast    = last;
    bus.req_rready = rr;
    settle();
  endtask

  initial begin
    logic [2:0] pending;
    int g, b, rx;
    logic done, stall;

`ifdef MEM_ARB_RR_EN
    order[0] = 0; order[1] = 1; order[2] = 2; rst_gnt = 0;
`else
    order[0] = 1; order[1] = 2; order[2] = 0; rst_gnt = 1;
`endif
    for (int i = 0; i < N_REQ; i++) begin
      p_addr[i] = '0; p_len[i] = '0; p_size[i] = '0;
    end

    //           arv    ar    rv    rl    rdata         rr      e_ar    e_av  e_addr         id    e_rv    e_rr  busy
    tv[0] = '{3'b010, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 3'b000, 3'b010, 1'b0, 32'h0,         4'h0, 3'b000, 1'b0, 1'b0};
    tv[1] = '{3'b000, 1'b1, 1'b1, 1'b0, 32'hDEAD_0000, 3'b010, 3'b000, 1'b1, 32'h1FC0_0040, 4'h1, 3'b000, 1'b0, 1'b1};
    tv[2] = '{3'b000, 1'b0, 1'b1, 1'b0, 32'hA0A0_0000, 3'b010, 3'b000, 1'b0, 32'h1FC0_0040, 4'h1, 3'b010, 1'b1, 1'b1};
    tv[3] = '{3'b000, 1'b0, 1'b1, 1'b0, 32'hA0A0_0001, 3'b010, 3'b000, 1'b0, 32'h1FC0_0040, 4'h1, 3'b010, 1'b1, 1'b1};
    tv[4] = '{3'b000, 1'b0, 1'b1, 1'b0, 32'hA0A0_0002, 3'b010, 3'b000, 1'b0, 32'h1FC0_0040, 4'h1, 3'b010, 1'b1, 1'b1};
    tv[5] = '{3'b000, 1'b0, 1'b1, 1'b1, 32'hA0A0_0003, 3'b010, 3'b000, 1'b0, 32'h1FC0_0040, 4'h1, 3'b010, 1'b1, 1'b1};
    tv[6] = '{3'b000, 1'b0, 1'b1, 1'b0, 32'hBEEF_0000, 3'b010, 3'b000, 1'b0, 32'h1FC0_0040, 4'h1, 3'b000, 1'b0, 1'b0};

    // reset values, with every requester asking during reset
    idle_inputs();
    rst = 1'b0;
    #1 rst = 1'b1;
    bus.req_arvalid = 3'b111;
    settle();
    chk("rst_arready", bus.req_arready, 0);
    chk("rst_m_arvalid", bus.m_arvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_m_araddr", bus.m_araddr, 0);
    chk("rst_rvalid", bus.req_rvalid, 0);
    do_reset();

    // single burst from the DCache requester
    p_addr[1] = 32'h1FC0_0040; p_len[1] = 8'd3; p_size[1] = 3'd2;
    for (int k = 0; k < 7; k++) begin
      tick();
      bus.req_arvalid = tv[k].arvalid;
      bus.m_arready   = tv[k].m_arready;
      bus.m_rvalid    = tv[k].m_rvalid;
      bus.m_rlast     = tv[k].m_rlast;
      bus.m_rdata     = tv[k].m_rdata;
      bus.req_rready  = tv[k].rready;
      settle();
      chk($sformatf("t1_arready[%0d]", k), bus.req_arready, tv[k].e_arready);
      chk($sformatf("t1_m_arvalid[%0d]", k), bus.m_arvalid, tv[k].e_arvalid);
      chk($sformatf("t1_m_araddr[%0d]", k), bus.m_araddr, tv[k].e_araddr);
      chk($sformatf("t1_m_arid[%0d]", k), bus.m_arid, tv[k].e_arid);
      chk($sformatf("t1_rvalid[%0d]", k), bus.req_rvalid, tv[k].e_rvalid);
      chk($sformatf("t1_m_rready[%0d]", k), bus.m_rready, tv[k].e_rready);
      chk($sformatf("t1_busy[%0d]", k), busy, tv[k].e_busy);
      chk($sformatf("t1_rdata[%0d]", k), bus.req_rdata, tv[k].m_rdata);
      chk($sformatf("t1_err[%0d]", k), err, 0);
    end
    chk("t1_m_arlen", bus.m_arlen, 3);
    chk("t1_m_arsize", bus.m_arsize, 2);
    chk("t1_m_arburst", bus.m_arburst, 1);

    // AR stall: address phase held while the requester changes its payload
    p_addr[0] = 32'h8000_0100; p_len[0] = 8'd0; p_size[0] = 3'd2;
    tick();
    idle_inputs();
    bus.req_arvalid = 3'b001;
    settle();
    chk("t2_arready", bus.req_arready, 3'b001);
    for (int c = 0; c < 5; c++) begin
      tick();
      bus.req_arvalid = '0;
      bus.m_arready   = 1'b0;
      bus.m_rvalid    = 1'b1;
      bus.req_rready  = 3'b001;
      p_addr[0]       = 32'h0BAD_0000 + c;
      settle();
      chk("t2_m_arvalid", bus.m_arvalid, 1);
      chk("t2_m_araddr", bus.m_araddr, 32'h8000_0100);
      chk("t2_m_arid", bus.m_arid, 0);
      chk("t2_rvalid", bus.req_rvalid, 0);
      chk("t2_m_rready", bus.m_rready, 0);
    end
    tick();
    bus.m_arready = 1'b1;
    bus.m_rvalid  = 1'b0;
    settle();
    chk("t2_m_arvalid_hs", bus.m_arvalid, 1);
    beat(32'h1234_5678, 1'b1, 3'b001);
    bus.m_rresp = 2'b10;
    #1;
    chk("t2_rvalid_data", bus.req_rvalid, 3'b001);
    chk("t2_m_rready_data", bus.m_rready, 1);
    chk("t2_rresp", bus.req_rresp, 2);
    chk("t2_rlast", bus.req_rlast, 1);
    tick();
    idle_inputs();
    settle();
    chk("t2_busy_end", busy, 0);
    chk("t2_m_arvalid_end", bus.m_arvalid, 0);

    // simultaneous requests from reset, arlen=0 each
    do_reset();
    for (int i = 0; i < N_REQ; i++) p_len[i] = 8'd0;
    pending = 3'b111;
    for (int n = 0; n < 3; n++) begin
      g = order[n];
      tick();
      idle_inputs();
      bus.req_arvalid = pending;
      settle();
      chk($sformatf("t3_grant[%0d]", n), bus.req_arready, oh(g));
      pending = pending & ~oh(g);
      tick();
      bus.req_arvalid = pending;
      bus.m_arready   = 1'b1;
      settle();
      chk($sformatf("t3_arid[%0d]", n), bus.m_arid, g);
      chk($sformatf("t3_arready_addr[%0d]", n), bus.req_arready, 0);
      tick();
      bus.m_arready  = 1'b0;
      bus.m_rvalid   = 1'b1;
      bus.m_rlast    = 1'b1;
      bus.m_rdata    = 32'hC000_0000 + n;
      bus.req_rready = 3'b111;
      settle();
      chk($sformatf("t3_rvalid[%0d]", n), bus.req_rvalid, oh(g));
      chk($sformatf("t3_arready_data[%0d]", n), bus.req_arready, 0);
    end
    tick();
    idle_inputs();
    settle();
    chk("t3_busy_end", busy, 0);
    chk("t3_err_end", err, 0);

    // back-pressure from the uncache requester mid-burst
    p_addr[2] = 32'h4000_0000; p_len[2] = 8'd3; p_size[2] = 3'd2;
    start_burst(2, 3'b100);
    b = 0; rx = 0; done = 1'b0;
    for (int c = 0; c < 12 && !done; c++) begin
      stall = (c >= 1 && c <= 3);
      tick();
      bus.req_arvalid = '0;
      bus.m_arready   = 1'b0;
      bus.m_rvalid    = 1'b1;
      bus.m_rdata     = 32'hB000_0000 + b;
      bus.m_rlast     = (b == 3);
      bus.req_rready  = stall ? 3'b000 : 3'b100;
      settle();
      if (stall) begin
        chk("t4_m_rready_stall", bus.m_rready, 0);
        chk("t4_rvalid_stall", bus.req_rvalid, 3'b100);
      end
      if (bus.req_rvalid[2] && bus.req_rready[2]) begin
        chk("t4_data", bus.req_rdata, 32'hB000_0000 + rx);
        rx++;
      end
      if (bus.m_rvalid && bus.m_rready) begin
        if (bus.m_rlast) done = 1'b1;
        b++;
      end
    end
    chk("t4_done", done, 1);
    chk("t4_beats", rx, 4);
    tick();
    idle_inputs();
    settle();
    chk("t4_busy_end", busy, 0);
    chk("t4_err_end", err, 0);

    // early RLAST on the third beat of a four-beat burst
    p_addr[1] = 32'h2000_0000; p_len[1] = 8'd3;
    start_burst(1, 3'b010);
    beat(32'hE000_0000, 1'b0, 3'b010);
    beat(32'hE000_0001, 1'b0, 3'b010);
    chk("t5_err_before", err, 0);
    beat(32'hE000_0002, 1'b1, 3'b010);
    tick();
    idle_inputs();
    bus.req_arvalid = 3'b001;
    settle();
    chk("t5_err_set", err, 1);
    chk("t5_busy_idle", busy, 0);
    chk("t5_next_arready", bus.req_arready, 3'b001);
    tick();
    bus.req_arvalid = '0;
    bus.m_arready   = 1'b1;
    settle();
    chk("t5_next_arid", bus.m_arid, 0);
    beat(32'hE000_0010, 1'b1, 3'b001);
    chk("t5_next_rvalid", bus.req_rvalid, 3'b001);
    tick();
    idle_inputs();
    settle();
    chk("t5_err_sticky", err, 1);
    chk("t5_busy_end", busy, 0);

    // asynchronous reset after two of four beats
    p_len[2] = 8'd3;
    start_burst(2, 3'b100);
    beat(32'hF000_0000, 1'b0, 3'b100);
    beat(32'hF000_0001, 1'b0, 3'b100);
    tick();
    bus.m_rdata = 32'hF000_0002;
    rst = 1'b1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_err", err, 0);
    chk("t6_rvalid", bus.req_rvalid, 0);
    chk("t6_m_rready", bus.m_rready, 0);
    chk("t6_m_arvalid", bus.m_arvalid, 0);
    chk("t6_m_arid", bus.m_arid, 0);
    chk("t6_m_araddr", bus.m_araddr, 0);
    chk("t6_m_arlen", bus.m_arlen, 0);
    tick();
    rst = 1'b0;
    settle();
    chk("t6_rvalid_post", bus.req_rvalid, 0);
    chk("t6_m_rready_post", bus.m_rready, 0);
    for (int i = 0; i < N_REQ; i++) p_len[i] = 8'd0;
    start_burst(rst_gnt, 3'b111);
    beat(32'hF100_0000, 1'b1, 3'b111);
    chk("t6_rvalid_new", bus.req_rvalid, oh(rst_gnt));
    tick();
    idle_inputs();
    settle();
    chk("t6_busy_end", busy, 0);

    // missing RLAST on the expected final beat
    p_len[1] = 8'd0;
    start_burst(1, 3'b010);
    beat(32'hD000_0000, 1'b0, 3'b010);
    chk("t7_err_before", err, 0);
    beat(32'hD000_0001, 1'b1, 3'b010);
    chk("t7_err_set", err, 1);
    chk("t7_busy", busy, 1);
    tick();
    idle_inputs();
    settle();
    chk("t7_busy_end", busy, 0);
    chk("t7_err_sticky", err, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
